// File: rtl/dmem_switch_io_if.sv
// dmem_switch_io_if: processor load-path signals between the core, data ROM and switch stage
interface dmem_switch_io_if;
  logic [31:0] a;
  logic        re;
  logic [31:0] mem_rd;
  logic [31:0] rd;
  modport master (output a, re, mem_rd, input rd);
  modport slave (input a, re, mem_rd, output rd);
endinterface

// File: rtl/dmem_switch_io.sv
// dmem_switch_io: debounced switch status word muxed into the data-memory read path
module dmem_switch_io #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] SW_ADDR         = 32'd256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             switch1,
  input  logic             switch2,
  dmem_switch_io_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state, state_n;
  logic [1:0] sync1, sw_sync, cand, cand_n, stable, stable_n;
  logic [CW-1:0] cnt, cnt_n;
  logic changed, changed_n, commit, sw_hit;
  assign sw_hit = bus.a == SW_ADDR;
  assign bus.rd = sw_hit ? {29'b0, changed, stable} : bus.mem_rd;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sw_sync <= '0;
      state   <= IDLE;
      cand    <= '0;
      stable  <= '0;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      sync1   <= {switch1, switch2};
      sw_sync <= sync1;
      state   <= state_n;
      cand    <= cand_n;
      stable  <= stable_n;
      cnt     <= cnt_n;
      changed <= changed_n;
    end
  end
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    stable_n = stable;
    cnt_n    = cnt;
    commit   = 1'b0;
    if (state == IDLE) begin
      if (sw_sync != stable) begin
        state_n = COUNT;
        cand_n  = sw_sync;
        cnt_n   = '0;
      end
    end else if (sw_sync == stable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (sw_sync != cand) begin
      cand_n = sw_sync;
      cnt_n  = '0;
    end else if (cnt == LAST) begin
      stable_n = cand;
      commit   = 1'b1;
      state_n  = IDLE;
      cnt_n    = '0;
    end else begin
      cnt_n = cnt + CW'(1);
    end
    // a commit on the same edge as a status read keeps the new change visible
    changed_n = commit ? 1'b1 : (bus.re && sw_hit) ? 1'b0 : changed;
  end
endmodule

// File: tb/tb_dmem_switch_io.sv
// tb_dmem_switch_io: directed and randomized checks of the switch status read path against a run-length model
module tb_dmem_switch_io;
  localparam int D = 4;
  logic clk, reset_n, switch1, switch2;
  int n_vec = 0;
  int n_err = 0;
  dmem_switch_io_if bus();
  dmem_switch_io #(.DEBOUNCE_CYCLES(D), .SW_ADDR(32'd256)) dut (
    .clk(clk), .reset_n(reset_n), .switch1(switch1), .switch2(switch2), .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
  // model: a new value commits once the synchronized input has shown it for D+1 consecutive samples
  logic [1:0] m_s1, m_s2, m_stable, run_val, s;
  logic m_changed, m_commit;
  int run_len;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_changed = 0; run_val = 0; run_len = 0;
    end else begin
      s = m_s2;
      m_commit = 0;
      if (s == m_stable) run_len = 0;
      else if (run_len > 0 && s == run_val) run_len++;
      else begin run_val = s; run_len = 1; end
      if (run_len == D + 1) begin m_stable = s; run_len = 0; m_commit = 1; end
      if (m_commit) m_changed = 1;
      else if (bus.re && bus.a == 32'd256) m_changed = 0;
      m_s2 = m_s1;
      m_s1 = {switch1, switch2};
    end
  end
  function automatic logic [31:0] model_rd();
    return (bus.a == 32'd256) ? {29'b0, m_changed, m_stable} : bus.mem_rd;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: rd=%h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model", bus.rd, model_rd());
  endtask
  initial begin
    reset_n = 0; {switch1, switch2} = 2'b11;
    bus.a = 32'd256; bus.re = 0; bus.mem_rd = $urandom;
    tick(); tick();
    check("reset_rd", bus.rd, 32'h0);
    reset_n = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("reset_commit", bus.rd, k == 7 ? 32'h7 : 32'h0);
    end
    bus.a = 32'd260; bus.mem_rd = 32'hDEADBEEF;
    #1 check("pass_11", bus.rd, 32'hDEADBEEF);
    {switch1, switch2} = 2'b00;
    #1 check("pass_00", bus.rd, 32'hDEADBEEF);
    reset_n = 0; bus.a = 32'd256;
    tick();
    reset_n = 1;
    tick(); tick();
    switch1 = 1;
    repeat (3) begin tick(); check("glitch_hi", bus.rd, 32'h0); end
    switch1 = 0;
    repeat (8) begin tick(); check("glitch_lo", bus.rd, 32'h0); end
    {switch1, switch2} = 2'b01;
    repeat (2) begin tick(); check("bounce_01", bus.rd, 32'h0); end
    {switch1, switch2} = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("bounce_commit", bus.rd, k == 7 ? 32'h6 : 32'h0);
    end
    bus.re = 1; bus.a = 32'd260;
    tick();
    bus.re = 0; bus.a = 32'd256;
    #1 check("no_clear_other", bus.rd, 32'h6);
    bus.re = 1;
    #1 check("pre_clear", bus.rd, 32'h6);
    tick();
    bus.re = 0;
    check("cleared", bus.rd, 32'h2);
    {switch1, switch2} = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("coll_wait", bus.rd, 32'h2);
    end
    bus.re = 1;
    #1 check("coll_old", bus.rd, 32'h2);
    tick();
    bus.re = 0;
    check("coll_new", bus.rd, 32'h7);
    tick();
    check("coll_hold", bus.rd, 32'h7);
    {switch1, switch2} = 2'b01;
    repeat (3) tick();
    #2 reset_n = 0;
    #1 check("async_reset", bus.rd, 32'h0);
    @(negedge clk);
    reset_n = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("midcount_reset", bus.rd, k == 7 ? 32'h5 : 32'h0);
    end
    repeat (600) begin
      int r;
      if ($urandom_range(5) == 0) {switch1, switch2} = 2'($urandom);
      r = $urandom_range(3);
      bus.a = (r < 2) ? 32'd256 : (r == 2) ? 32'd260 : $urandom;
      bus.re = ($urandom_range(3) == 0);
      bus.mem_rd = $urandom;
      if ($urandom_range(99) == 0) begin
        #2 reset_n = 0;
        #2 reset_n = 1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_switch_io.md
# dmem_switch_io

Memory-mapped switch input stage placed directly upstream of the data-memory read path. It synchronizes and debounces the two board switches (switch1, switch2) and produces a stable 2-bit code plus a sticky "changed" flag. Reads at the switch address return this status; all other addresses pass the ROM data word through unchanged. The processor load path consumes the muxed `rd` in place of the raw ROM output.

## Interface

- DEBOUNCE_CYCLES, 50000, number of consecutive clk cycles a new synchronized switch value must hold before it is committed (1 ms at 50 MHz); legal range ≥ 2.
- SW_ADDR, 32'd256, byte address of the switch status word.

- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- switch1  in  1  raw switch, asynchronous to clk; bit 1 of the code.
- switch2  in  1  raw switch, asynchronous to clk; bit 0 of the code.
- a  in  32  data address from the processor.
- re  in  1  load strobe; high for one cycle when the processor reads `a`.
- mem_rd  in  32  read data from the data ROM.
- rd  out  32  read data to the processor.

## Operation

- Synchronizer: 2-flop chain on the 2-bit vector {switch1, switch2} → `sw_sync`.
- Debounce FSM, states IDLE and COUNT; registers `cand[1:0]`, `stable[1:0]`, `cnt` ($clog2(DEBOUNCE_CYCLES) bits), `changed`.
  - IDLE: if sw_sync != stable → COUNT, cand <= sw_sync, cnt <= 0. Otherwise stay.
  - COUNT, sw_sync == stable: → IDLE, cnt <= 0 (bounce returned to old value).
  - COUNT, sw_sync != stable and != cand: cand <= sw_sync, cnt <= 0, stay in COUNT (restart).
  - COUNT, sw_sync == cand, cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - COUNT, sw_sync == cand, cnt == DEBOUNCE_CYCLES-1: stable <= cand, changed <= 1, → IDLE, cnt <= 0.
- Both switches are debounced as one vector; any change to either bit restarts the count.
- Read mux (combinational): rd = {29'b0, changed, stable} when a == SW_ADDR; otherwise rd = mem_rd. The full 32-bit address is compared.
- Clear-on-read: at a clk edge with re && a == SW_ADDR, changed <= 0.
- Simultaneous commit and clear-on-read in the same cycle: the commit wins and changed stays 1. The read returns the pre-edge value.
- No write path. Stores to SW_ADDR have no effect on this block.

## Timing

- Reset (reset_n low, asynchronous): sync flops 0, cand 0, stable 0, cnt 0, changed 0, state IDLE. Therefore rd = 0 at SW_ADDR and rd = mem_rd elsewhere.
- Reset deasserted mid-count: the count in progress is discarded. After release, switches already high are re-debounced from IDLE and commit with the normal latency.
- Latency: raw value first captured at edge N reaches sw_sync at edge N+1 and enters COUNT at edge N+2. stable/changed update at edge N+2+DEBOUNCE_CYCLES, provided the value holds.
- A glitch held fewer than DEBOUNCE_CYCLES synchronized cycles never reaches `stable`.
- rd has zero-cycle latency from a, mem_rd, stable and changed; the block adds no register stage on the read path.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset: hold reset_n=0 with switches=2'b11 and a=256 → rd=0. Release reset, hold switches → rd=32'h7 (changed=1, stable=11) at edge 6 after the first sampling edge, not before.
- Passthrough: a=260, mem_rd=32'hDEADBEEF → rd=32'hDEADBEEF in the same cycle, regardless of switch state.
- Glitch rejection: switch1 pulses high for 3 cycles, then low → stable stays 00, changed stays 0, rd at 256 = 0 throughout.
- Bounce restart: switches 00→01 for 2 cycles →10 held → stable=10 committed 6 edges after 10 is first sampled. Value 01 is never committed.
- Clear-on-read: after commit (rd=32'h4|code), pulse re=1 with a=256 → next cycle rd=code only (bit 2 clear). re=1 with a=260 does not clear the flag.
- Collision: re=1, a=256 on the exact commit edge → changed=1 after the edge, and the read in that cycle returns the old status.
